// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the RAM port arbiter: requester identifiers used by the
// round-robin pointer and the pointer's reset value.
package ram_port_arbiter_pkg;

    typedef enum logic {
        RR_IF = 1'b0,
        RR_LS = 1'b1
    } rr_id_t;

    // Starting from "LS granted last" lets IF win the first contention.
    localparam rr_id_t RR_LAST_RST = RR_LS;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the arbiter: IF fetch port and LS load/store port.
// The slave modport is the arbiter's view; the master modport is the pipeline's view.
interface ram_port_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    localparam int BE_W = DATA_W / 8;

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [DATA_W-1:0] o_if_rdata;

    logic              i_ls_req;
    logic              i_ls_we;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata;
    logic [BE_W-1:0]   i_ls_be;
    logic              o_ls_gnt;
    logic              o_ls_rvalid;
    logic [DATA_W-1:0] o_ls_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata
    );

endinterface

// File: rtl/ram_port_arbiter_be_expand.sv
// Expands byte strobes into a per-bit write mask: every bit of byte k copies strobe k.
module be_expand #(
    parameter int BE_W = 8
) (
    input  logic [BE_W-1:0]   i_be,
    output logic [BE_W*8-1:0] o_mask
);

    for (genvar k = 0; k < BE_W; k++) begin : g_byte
        assign o_mask[k*8 +: 8] = {8{i_be[k]}};
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a two-port RAM between instruction fetch (read) and load/store (read/write):
// round-robin on the read port, LS owns the write port, 1-cycle read latency.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    ram_port_arbiter_if.slave bus,
    output logic              o_mem_reb0,
    output logic [ADDR_W-1:0] o_mem_addr0,
    input  logic [DATA_W-1:0] i_mem_rdata0,
    output logic              o_mem_web1,
    output logic [DATA_W-1:0] o_mem_bweb1,
    output logic [ADDR_W-1:0] o_mem_addr1,
    output logic [DATA_W-1:0] o_mem_wdata1
);

    localparam int BE_W = DATA_W / 8;

    rr_id_t            r_rr_last;
    logic              r_if_rvalid;
    logic              r_ls_rvalid;

    logic              w_ls_wr;
    logic              w_ls_rd_req;
    logic              w_collide;
    logic              w_if_cand;
    logic              w_if_gnt;
    logic              w_ls_rd_gnt;
    logic              w_if_rvalid;
    logic              w_ls_rvalid;
    logic [DATA_W-1:0] w_bweb;

    be_expand #(.BE_W(BE_W)) u_be_expand (
        .i_be   (bus.i_ls_be),
        .o_mask (w_bweb)
    );

    // An IF read to the address LS is writing this cycle is held off one cycle,
    // so the RAM never sees read-during-write and IF gets the fresh data.
    always_comb begin
        w_ls_wr     = i_rst_n & bus.i_ls_req & bus.i_ls_we;
        w_ls_rd_req = i_rst_n & bus.i_ls_req & ~bus.i_ls_we;
        w_collide   = w_ls_wr & bus.i_if_req & (bus.i_if_addr == bus.i_ls_addr);
        w_if_cand   = i_rst_n & bus.i_if_req & ~w_collide;
        w_if_gnt    = w_if_cand & (~w_ls_rd_req | (r_rr_last == RR_LS));
        w_ls_rd_gnt = w_ls_rd_req & (~w_if_cand | (r_rr_last == RR_IF));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_last   <= RR_LAST_RST;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_ls_rvalid <= w_ls_rd_gnt;
            if (w_if_gnt) begin
                r_rr_last <= RR_IF;
            end else if (w_ls_rd_gnt) begin
                r_rr_last <= RR_LS;
            end
        end
    end

    // Gating with reset drops a response whose grant came just before reset.
    always_comb begin
        w_if_rvalid = r_if_rvalid & i_rst_n;
        w_ls_rvalid = r_ls_rvalid & i_rst_n;
    end

    always_comb begin
        bus.o_if_gnt    = w_if_gnt;
        bus.o_ls_gnt    = w_ls_wr | w_ls_rd_gnt;
        bus.o_if_rvalid = w_if_rvalid;
        bus.o_ls_rvalid = w_ls_rvalid;
        bus.o_if_rdata  = w_if_rvalid ? i_mem_rdata0 : '0;
        bus.o_ls_rdata  = w_ls_rvalid ? i_mem_rdata0 : '0;

        o_mem_reb0   = w_if_gnt | w_ls_rd_gnt;
        o_mem_addr0  = w_if_gnt    ? bus.i_if_addr :
                       w_ls_rd_gnt ? bus.i_ls_addr : '0;

        o_mem_web1   = w_ls_wr;
        o_mem_addr1  = w_ls_wr ? bus.i_ls_addr  : '0;
        o_mem_wdata1 = w_ls_wr ? bus.i_ls_wdata : '0;
        o_mem_bweb1  = w_ls_wr ? w_bweb         : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_port_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 10;
    localparam int BE_W   = DATA_W / 8;

    logic              clk;
    logic              rstN;
    logic              memReb0;
    logic [ADDR_W-1:0] memAddr0;
    logic [DATA_W-1:0] memRdata0;
    logic              memWeb1;
    logic [DATA_W-1:0] memBweb1;
    logic [ADDR_W-1:0] memAddr1;
    logic [DATA_W-1:0] memWdata1;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .bus          (bus.slave),
        .o_mem_reb0   (memReb0),
        .o_mem_addr0  (memAddr0),
        .i_mem_rdata0 (memRdata0),
        .o_mem_web1   (memWeb1),
        .o_mem_bweb1  (memBweb1),
        .o_mem_addr1  (memAddr1),
        .o_mem_wdata1 (memWdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: unwritten words hold a fixed pattern, word 0x005 starts as all ones.
    logic [DATA_W-1:0] memArray [0:(1<<ADDR_W)-1];
    logic              memWritten [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] initWord(input logic [ADDR_W-1:0] a);
        if (a == 10'h005) return '1;
        return 64'hDEAD_BEEF_0000_0000 | DATA_W'(a);
    endfunction

    always @(posedge clk) begin
        if (memWeb1) begin
            memArray[memAddr1]   <= ((memWritten[memAddr1] === 1'b1 ? memArray[memAddr1] : initWord(memAddr1)) & ~memBweb1)
                                    | (memWdata1 & memBweb1);
            memWritten[memAddr1] <= 1'b1;
        end
        if (memReb0) begin
            memRdata0 <= (memWritten[memAddr0] === 1'b1) ? memArray[memAddr0] : initWord(memAddr0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        bus.i_if_req   = 1'b0;
        bus.i_if_addr  = '0;
        bus.i_ls_req   = 1'b0;
        bus.i_ls_we    = 1'b0;
        bus.i_ls_addr  = '0;
        bus.i_ls_wdata = '0;
        bus.i_ls_be    = '0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 10'h010;
        bus.i_ls_req  = 1'b1;
        bus.i_ls_addr = 10'h020;
        for (int i = 0; i < 3; i++) begin
            bus.i_ls_we = (i == 1);
            #1;
            checks++;
            if (bus.o_if_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_gnt cyc%0d: got %b expected 0", i, bus.o_if_gnt); end
            checks++;
            if (bus.o_ls_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_ls_gnt cyc%0d: got %b expected 0", i, bus.o_ls_gnt); end
            checks++;
            if (memReb0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_reb0 cyc%0d: got %b expected 0", i, memReb0); end
            checks++;
            if (memWeb1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_web1 cyc%0d: got %b expected 0", i, memWeb1); end
            tick();
        end
        checks++;
        if (bus.o_if_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_rvalid: got %b expected 0", bus.o_if_rvalid); end
        rstN = 1'b1;
        bus.i_ls_we = 1'b0;
        #1;
        checks++;
        if (bus.o_if_gnt !== 1'b1 || bus.o_ls_gnt !== 1'b0) begin
            errors++; $display("[TB] FAIL first_contention: got if=%b ls=%b expected if=1 ls=0", bus.o_if_gnt, bus.o_ls_gnt);
        end
        tick();
        idleAll();
        #1;
        checks++;
        if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 64'hDEAD_BEEF_0000_0010) begin
            errors++; $display("[TB] FAIL first_read: got v=%b d=%h expected v=1 d=deadbeef00000010", bus.o_if_rvalid, bus.o_if_rdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic prevIf;
        logic expIf;
        rstN = 1'b0;
        idleAll();
        tick();
        rstN = 1'b1;
        prevIf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                checks++;
                if (bus.o_if_rvalid !== prevIf || bus.o_ls_rvalid !== !prevIf) begin
                    errors++; $display("[TB] FAIL rr_rvalid cyc%0d: got if=%b ls=%b expected if=%b ls=%b", i, bus.o_if_rvalid, bus.o_ls_rvalid, prevIf, !prevIf);
                end
                checks++;
                if (prevIf && bus.o_if_rdata !== 64'hDEAD_BEEF_0000_0010) begin
                    errors++; $display("[TB] FAIL rr_if_rdata cyc%0d: got %h expected deadbeef00000010", i, bus.o_if_rdata);
                end else if (!prevIf && bus.o_ls_rdata !== 64'hDEAD_BEEF_0000_0020) begin
                    errors++; $display("[TB] FAIL rr_ls_rdata cyc%0d: got %h expected deadbeef00000020", i, bus.o_ls_rdata);
                end
            end
            if (i < 4) begin
                expIf = (i % 2 == 0);
                bus.i_if_req  = 1'b1;
                bus.i_if_addr = 10'h010;
                bus.i_ls_req  = 1'b1;
                bus.i_ls_we   = 1'b0;
                bus.i_ls_addr = 10'h020;
                #1;
                checks++;
                if (bus.o_if_gnt !== expIf || bus.o_ls_gnt !== !expIf) begin
                    errors++; $display("[TB] FAIL rr_gnt cyc%0d: got if=%b ls=%b expected if=%b ls=%b", i, bus.o_if_gnt, bus.o_ls_gnt, expIf, !expIf);
                end
                checks++;
                if (memReb0 !== 1'b1 || memAddr0 !== (expIf ? 10'h010 : 10'h020)) begin
                    errors++; $display("[TB] FAIL rr_addr0 cyc%0d: got reb=%b a=%h expected reb=1 a=%h", i, memReb0, memAddr0, expIf ? 10'h010 : 10'h020);
                end
                prevIf = expIf;
            end else begin
                idleAll();
            end
            tick();
        end
    endtask

    task automatic test_write_then_read();
        bus.i_ls_req   = 1'b1;
        bus.i_ls_we    = 1'b1;
        bus.i_ls_addr  = 10'h005;
        bus.i_ls_wdata = 64'h1122_3344_5566_7788;
        bus.i_ls_be    = 8'h0F;
        #1;
        checks++;
        if (bus.o_ls_gnt !== 1'b1 || memWeb1 !== 1'b1 || memReb0 !== 1'b0) begin
            errors++; $display("[TB] FAIL wr_gnt: got gnt=%b web=%b reb=%b expected 1 1 0", bus.o_ls_gnt, memWeb1, memReb0);
        end
        checks++;
        if (memBweb1 !== 64'h0000_0000_FFFF_FFFF || memAddr1 !== 10'h005 || memWdata1 !== 64'h1122_3344_5566_7788) begin
            errors++; $display("[TB] FAIL wr_drive: got bweb=%h a=%h d=%h expected 00000000ffffffff 005 1122334455667788", memBweb1, memAddr1, memWdata1);
        end
        tick();
        checks++;
        if (bus.o_ls_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_rvalid: got %b expected 0", bus.o_ls_rvalid); end
        bus.i_ls_we = 1'b0;
        bus.i_ls_be = '0;
        #1;
        checks++;
        if (bus.o_ls_gnt !== 1'b1 || memAddr0 !== 10'h005 || memWeb1 !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_gnt: got gnt=%b a=%h web=%b expected 1 005 0", bus.o_ls_gnt, memAddr0, memWeb1);
        end
        tick();
        idleAll();
        #1;
        checks++;
        if (bus.o_ls_rvalid !== 1'b1 || bus.o_ls_rdata !== 64'hFFFF_FFFF_5566_7788) begin
            errors++; $display("[TB] FAIL rd_data: got v=%b d=%h expected v=1 d=ffffffff55667788", bus.o_ls_rvalid, bus.o_ls_rdata);
        end
        checks++;
        if (memAddr0 !== '0 || memAddr1 !== '0 || memWdata1 !== '0 || memBweb1 !== '0 || memReb0 !== 1'b0 || memWeb1 !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_drive: got a0=%h a1=%h wd=%h bw=%h reb=%b web=%b expected all 0", memAddr0, memAddr1, memWdata1, memBweb1, memReb0, memWeb1);
        end
        tick();
    endtask

    task automatic test_collision();
        bus.i_ls_req   = 1'b1;
        bus.i_ls_we    = 1'b1;
        bus.i_ls_addr  = 10'h040;
        bus.i_ls_wdata = 64'hCAFE_BABE_1234_5678;
        bus.i_ls_be    = 8'hFF;
        bus.i_if_req   = 1'b1;
        bus.i_if_addr  = 10'h040;
        #1;
        checks++;
        if (bus.o_if_gnt !== 1'b0 || bus.o_ls_gnt !== 1'b1 || memReb0 !== 1'b0) begin
            errors++; $display("[TB] FAIL coll_hold: got if=%b ls=%b reb=%b expected 0 1 0", bus.o_if_gnt, bus.o_ls_gnt, memReb0);
        end
        tick();
        bus.i_ls_req = 1'b0;
        bus.i_ls_we  = 1'b0;
        bus.i_ls_be  = '0;
        #1;
        checks++;
        if (bus.o_if_gnt !== 1'b1 || memAddr0 !== 10'h040 || bus.o_if_rvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL coll_retry: got gnt=%b a=%h v=%b expected 1 040 0", bus.o_if_gnt, memAddr0, bus.o_if_rvalid);
        end
        tick();
        idleAll();
        #1;
        checks++;
        if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 64'hCAFE_BABE_1234_5678) begin
            errors++; $display("[TB] FAIL coll_data: got v=%b d=%h expected v=1 d=cafebabe12345678", bus.o_if_rvalid, bus.o_if_rdata);
        end
        tick();
    endtask

    task automatic test_parallel();
        bus.i_ls_req   = 1'b1;
        bus.i_ls_we    = 1'b1;
        bus.i_ls_addr  = 10'h041;
        bus.i_ls_wdata = 64'h0123_4567_89AB_CDEF;
        bus.i_ls_be    = 8'hFF;
        bus.i_if_req   = 1'b1;
        bus.i_if_addr  = 10'h042;
        #1;
        checks++;
        if (bus.o_if_gnt !== 1'b1 || bus.o_ls_gnt !== 1'b1 || memWeb1 !== 1'b1 || memReb0 !== 1'b1) begin
            errors++; $display("[TB] FAIL par_gnt: got if=%b ls=%b web=%b reb=%b expected all 1", bus.o_if_gnt, bus.o_ls_gnt, memWeb1, memReb0);
        end
        tick();
        idleAll();
        #1;
        checks++;
        if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 64'hDEAD_BEEF_0000_0042 || bus.o_ls_rvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL par_data: got v=%b d=%h lsv=%b expected v=1 d=deadbeef00000042 lsv=0", bus.o_if_rvalid, bus.o_if_rdata, bus.o_ls_rvalid);
        end
        tick();
    endtask

    task automatic test_reset_drop();
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 10'h010;
        #1;
        checks++;
        if (bus.o_if_gnt !== 1'b1) begin errors++; $display("[TB] FAIL drop_gnt: got %b expected 1", bus.o_if_gnt); end
        tick();
        rstN = 1'b0;
        idleAll();
        #1;
        checks++;
        if (bus.o_if_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_n1: got %b expected 0", bus.o_if_rvalid); end
        tick();
        rstN = 1'b1;
        #1;
        checks++;
        if (bus.o_if_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_n2: got %b expected 0", bus.o_if_rvalid); end
        tick();
        checks++;
        if (bus.o_if_rvalid !== 1'b0 || bus.o_ls_rvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_after: got if=%b ls=%b expected 0 0", bus.o_if_rvalid, bus.o_ls_rvalid);
        end
    endtask

    initial begin
        idleAll();
        rstN = 1'b0;
        tick();
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_collision();
        test_parallel();
        test_reset_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
